// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch front end.
package fetch_pkg;

  localparam int          INSTR_W          = 32;
  localparam int          ENTRY_W          = 2 * INSTR_W;
  localparam logic [31:0] PC_STEP          = 32'd4;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    DRAIN = 2'd2
  } fetch_state_e;

  function automatic logic [INSTR_W-1:0] word_align(input logic [INSTR_W-1:0] a);
    return a & ~32'h0000_0003;
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous first-word-fall-through queue; flush wins over push and pop.
module fetch_fifo #(
  parameter  int WIDTH = 64,
  parameter  int DEPTH = 4,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = AW + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  input  logic             flush,
  output logic [CW-1:0]    count,
  output logic [WIDTH-1:0] head
);

  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic             do_push, do_pop;

  always_comb begin
    do_push  = push && !flush;
    do_pop   = pop && !flush && (count_q != '0);
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    mem_d    = mem_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) begin
        mem_d[wr_ptr_q] = push_data;
        wr_ptr_d        = wr_ptr_q + 1'b1;
      end
      if (do_pop) rd_ptr_d = rd_ptr_q + 1'b1;
      count_d = count_q + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage carries no reset; entries are only observed once counted.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign count = count_q;
  assign head  = mem_q[rd_ptr_q];

endmodule

// File: rtl/imem_fetch_queue.sv
// Fetch front end: owns the fetch PC, issues sequential word requests and
// buffers returned words with their PC+4 for the IF stage.
//
// state | meaning
// IDLE  | no request outstanding; issue fetch PC when the queue has room
// WAIT  | request outstanding; its data is pushed on ack
// DRAIN | stale request outstanding after a redirect; its data is dropped
module imem_fetch_queue
  import fetch_pkg::*;
#(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               redirect,
  input  logic [INSTR_W-1:0] redirect_pc,
  input  logic               if_ready,
  output logic               if_valid,
  output logic [INSTR_W-1:0] if_instr,
  output logic [INSTR_W-1:0] if_pc_incr,
  output logic               mem_req,
  output logic [INSTR_W-1:0] mem_addr,
  input  logic               mem_ack,
  input  logic [INSTR_W-1:0] mem_rdata
);

  localparam int CW = $clog2(DEPTH) + 1;

  fetch_state_e       state_q, state_d;
  logic [INSTR_W-1:0] pc_q, pc_d;
  logic [INSTR_W-1:0] mem_addr_q, mem_addr_d;
  logic               mem_req_q, mem_req_d;
  logic [INSTR_W-1:0] target_pc;
  logic               fifo_push, fifo_pop, fifo_flush;
  logic [CW-1:0]      fifo_count;
  logic [ENTRY_W-1:0] fifo_head, push_entry;
  logic               has_space, space_after_push;

  assign target_pc        = word_align(redirect_pc);
  assign if_valid         = (fifo_count != '0);
  assign fifo_flush       = redirect;
  assign fifo_pop         = if_valid && if_ready && !redirect;
  assign has_space        = (fifo_count < CW'(DEPTH));
  // Room for another request once this cycle's push and pop have landed.
  assign space_after_push = fifo_pop || (fifo_count < CW'(DEPTH - 1));
  assign push_entry       = {mem_rdata, mem_addr_q + PC_STEP};

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      pc_q       <= word_align(RESET_PC);
      mem_req_q  <= 1'b0;
      mem_addr_q <= word_align(RESET_PC);
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      mem_req_q  <= mem_req_d;
      mem_addr_q <= mem_addr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (redirect || has_space) state_d = WAIT;
      WAIT: begin
        if (redirect)                          state_d = mem_ack ? WAIT : DRAIN;
        else if (mem_ack && !space_after_push) state_d = IDLE;
      end
      DRAIN:   if (mem_ack) state_d = WAIT;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    mem_req_d  = mem_req_q;
    mem_addr_d = mem_addr_q;
    pc_d       = pc_q;
    fifo_push  = 1'b0;
    case (state_q)
      IDLE: begin
        if (redirect) begin
          pc_d       = target_pc;
          mem_req_d  = 1'b1;
          mem_addr_d = target_pc;
        end else if (has_space) begin
          mem_req_d  = 1'b1;
          mem_addr_d = pc_q;
        end
      end
      WAIT: begin
        if (redirect) begin
          pc_d = target_pc;
          if (mem_ack) mem_addr_d = target_pc;
        end else if (mem_ack) begin
          fifo_push = 1'b1;
          pc_d      = mem_addr_q + PC_STEP;
          if (space_after_push) mem_addr_d = mem_addr_q + PC_STEP;
          else                  mem_req_d  = 1'b0;
        end
      end
      DRAIN: begin
        // pc_q already holds the redirect target; the stale word is dropped.
        if (redirect) pc_d = target_pc;
        if (mem_ack)  mem_addr_d = redirect ? target_pc : pc_q;
      end
      default: begin
        mem_req_d = 1'b0;
      end
    endcase
  end

  fetch_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (fifo_push),
    .push_data (push_entry),
    .pop       (fifo_pop),
    .flush     (fifo_flush),
    .count     (fifo_count),
    .head      (fifo_head)
  );

  assign mem_req    = mem_req_q;
  assign mem_addr   = mem_addr_q;
  assign if_instr   = fifo_head[ENTRY_W-1:INSTR_W];
  assign if_pc_incr = fifo_head[INSTR_W-1:0];

  ack_into_full: assert property (@(posedge clk) disable iff (rst)
    !(fifo_push && (fifo_count == CW'(DEPTH))));

endmodule

// File: tb/tb_imem_fetch_queue.sv
// Bench for imem_fetch_queue: vector table, directed corner sequences and a
// randomized run checked against a program-order reference model.
module tb_imem_fetch_queue;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        if_ready = 1'b0;
  logic        if_valid;
  logic [31:0] if_instr;
  logic [31:0] if_pc_incr;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ack = 1'b0;
  logic [31:0] mem_rdata = '0;

  int total = 0;
  int bad   = 0;

  int lat = 0;
  bit pending = 0;
  int cnt = 0;

  imem_fetch_queue #(.DEPTH(4), .RESET_PC(32'h0)) dut (
    .clk         (clk),
    .rst         (rst),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .if_ready    (if_ready),
    .if_valid    (if_valid),
    .if_instr    (if_instr),
    .if_pc_incr  (if_pc_incr),
    .mem_req     (mem_req),
    .mem_addr    (mem_addr),
    .mem_ack     (mem_ack),
    .mem_rdata   (mem_rdata)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  function automatic logic [31:0] img(input logic [31:0] a);
    if (a == 32'h0) return 32'h2008_0005;
    if (a == 32'h4) return 32'h2009_0003;
    return (a * 32'h9E37_79B9) ^ 32'h1357_2468;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Memory: acks 'lat' cycles after a request is first seen (lat<0: random 0..3).
  task automatic mem_drive();
    mem_ack = 1'b0;
    if (rst || !mem_req) begin
      pending = 0;
    end else begin
      if (!pending) begin
        pending = 1;
        cnt = (lat < 0) ? int'($urandom_range(0, 3)) : lat;
      end
      if (cnt == 0) begin
        mem_ack   = 1'b1;
        mem_rdata = img(mem_addr);
        pending   = 0;
      end else begin
        cnt--;
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    mem_drive();
  endtask

  task automatic do_reset();
    rst = 1'b1; redirect = 1'b0; if_ready = 1'b0;
    repeat (3) tick();
    chk("reset_mem_req", mem_req, 1'b0);
    chk("reset_mem_addr", mem_addr, 32'h0);
    chk("reset_if_valid", if_valid, 1'b0);
    rst = 1'b0;
  endtask

  typedef struct {
    bit          rst_before;
    int          latency;
    bit          ready;
    bit          exp_valid;
    logic [31:0] exp_instr;
    logic [31:0] exp_pcinc;
    bit          exp_req;
    logic [31:0] exp_addr;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(bit rb, int l, bit rd, bit v, logic [31:0] ins,
                              logic [31:0] pci, bit rq, logic [31:0] ad);
    vec_t t;
    t.rst_before = rb; t.latency = l; t.ready = rd; t.exp_valid = v;
    t.exp_instr = ins; t.exp_pcinc = pci; t.exp_req = rq; t.exp_addr = ad;
    return t;
  endfunction

  logic [31:0] exp_pc;
  int          pops;
  bit          prev_hold;
  logic [31:0] prev_addr;
  bit          found;

  initial begin
    // zero-wait stream with IF always ready
    vecs.push_back(mk(1, 0, 1, 0, 32'h0,         32'h0,  1, 32'h0));
    vecs.push_back(mk(0, 0, 1, 1, 32'h2008_0005, 32'h4,  1, 32'h4));
    vecs.push_back(mk(0, 0, 1, 1, 32'h2009_0003, 32'h8,  1, 32'h8));
    vecs.push_back(mk(0, 0, 1, 1, img(32'h8),    32'hC,  1, 32'hC));
    vecs.push_back(mk(0, 0, 1, 1, img(32'hC),    32'h10, 1, 32'h10));
    // IF stalled: queue fills to four, requests stop, then restart at 16
    vecs.push_back(mk(1, 0, 0, 0, 32'h0,         32'h0,  1, 32'h0));
    vecs.push_back(mk(0, 0, 0, 1, 32'h2008_0005, 32'h4,  1, 32'h4));
    vecs.push_back(mk(0, 0, 0, 1, 32'h2008_0005, 32'h4,  1, 32'h8));
    vecs.push_back(mk(0, 0, 0, 1, 32'h2008_0005, 32'h4,  1, 32'hC));
    vecs.push_back(mk(0, 0, 0, 1, 32'h2008_0005, 32'h4,  0, 32'hC));
    vecs.push_back(mk(0, 0, 1, 1, 32'h2008_0005, 32'h4,  0, 32'hC));
    vecs.push_back(mk(0, 0, 1, 1, 32'h2009_0003, 32'h8,  0, 32'hC));
    vecs.push_back(mk(0, 0, 1, 1, img(32'h8),    32'hC,  1, 32'h10));
    vecs.push_back(mk(0, 0, 1, 1, img(32'hC),    32'h10, 1, 32'h14));

    foreach (vecs[i]) begin
      lat = vecs[i].latency;
      if (vecs[i].rst_before) do_reset();
      tick();
      chk($sformatf("vec%0d_valid", i), if_valid, vecs[i].exp_valid);
      if (vecs[i].exp_valid) begin
        chk($sformatf("vec%0d_instr", i), if_instr, vecs[i].exp_instr);
        chk($sformatf("vec%0d_pc_incr", i), if_pc_incr, vecs[i].exp_pcinc);
      end
      chk($sformatf("vec%0d_mem_req", i), mem_req, vecs[i].exp_req);
      chk($sformatf("vec%0d_mem_addr", i), mem_addr, vecs[i].exp_addr);
      if_ready = vecs[i].ready;
    end

    // Redirect one cycle after a slow request to 8: drain, then fetch 0x40
    lat = 3;
    do_reset();
    if_ready = 1'b1;
    found = 0;
    for (int k = 0; k < 40 && !found; k++) begin
      tick();
      if (mem_req && mem_addr == 32'h8) found = 1;
    end
    chk("drain_req8_seen", found, 1'b1);
    tick();
    redirect = 1'b1; redirect_pc = 32'h40;
    tick();
    redirect = 1'b0;
    chk("drain_hold_req", mem_req, 1'b1);
    chk("drain_hold_addr", mem_addr, 32'h8);
    chk("drain_flushed", if_valid, 1'b0);
    tick();
    chk("drain_ack_addr", mem_addr, 32'h8);
    chk("drain_ack_seen", mem_ack, 1'b1);
    tick();
    chk("drain_new_req", mem_req, 1'b1);
    chk("drain_new_addr", mem_addr, 32'h40);
    chk("drain_word_dropped", if_valid, 1'b0);
    found = 0;
    for (int k = 0; k < 20 && !found; k++) begin
      tick();
      if (if_valid) found = 1;
    end
    chk("drain_valid_arrives", found, 1'b1);
    chk("drain_first_pc_incr", if_pc_incr, 32'h44);
    chk("drain_first_instr", if_instr, img(32'h40));

    // Redirect coincident with ack for 12 and a pop
    lat = 0;
    do_reset();
    if_ready = 1'b1;
    repeat (4) tick();
    chk("coinc_addr12", mem_addr, 32'hC);
    chk("coinc_valid_before", if_valid, 1'b1);
    redirect = 1'b1; redirect_pc = 32'h100;
    tick();
    redirect = 1'b0;
    chk("coinc_flushed", if_valid, 1'b0);
    chk("coinc_req", mem_req, 1'b1);
    chk("coinc_addr", mem_addr, 32'h100);
    tick();
    chk("coinc_valid_after", if_valid, 1'b1);
    chk("coinc_pc_incr", if_pc_incr, 32'h104);
    chk("coinc_instr", if_instr, img(32'h100));

    // Redirect to top of address space (low bits ignored), wrap to 0
    do_reset();
    if_ready = 1'b0;
    repeat (2) tick();
    redirect = 1'b1; redirect_pc = 32'hFFFF_FFFD;
    tick();
    redirect = 1'b0;
    chk("wrap_addr_top", mem_addr, 32'hFFFF_FFFC);
    chk("wrap_flushed", if_valid, 1'b0);
    tick();
    chk("wrap_valid", if_valid, 1'b1);
    chk("wrap_pc_incr", if_pc_incr, 32'h0);
    chk("wrap_instr", if_instr, img(32'hFFFF_FFFC));
    chk("wrap_next_addr", mem_addr, 32'h0);

    // Reset while waiting with two entries queued
    do_reset();
    repeat (3) tick();
    chk("rstmid_valid_before", if_valid, 1'b1);
    chk("rstmid_req_before", mem_req, 1'b1);
    chk("rstmid_addr_before", mem_addr, 32'h8);
    rst = 1'b1;
    tick();
    chk("rstmid_valid", if_valid, 1'b0);
    chk("rstmid_req", mem_req, 1'b0);
    chk("rstmid_addr", mem_addr, 32'h0);
    rst = 1'b0;
    tick();
    chk("rstmid_restart_req", mem_req, 1'b1);
    chk("rstmid_restart_addr", mem_addr, 32'h0);

    // Randomized run against a program-order model of the delivered stream
    lat = -1;
    do_reset();
    exp_pc = 32'h0;
    pops = 0;
    prev_hold = 0;
    prev_addr = '0;
    for (int c = 0; c < 4000; c++) begin
      tick();
      if (prev_hold) begin
        chk("rand_req_held", mem_req, 1'b1);
        chk("rand_addr_held", mem_addr, prev_addr);
      end
      chk("rand_addr_aligned", {30'h0, mem_addr[1:0]}, 32'h0);
      if_ready    = ($urandom_range(0, 3) != 0);
      redirect    = ($urandom_range(0, 19) == 0);
      redirect_pc = $urandom;
      prev_hold   = mem_req && !mem_ack;
      prev_addr   = mem_addr;
      if (redirect) begin
        exp_pc = redirect_pc & ~32'h3;
      end else if (if_valid && if_ready) begin
        chk("rand_pc_incr", if_pc_incr, exp_pc + 32'd4);
        chk("rand_instr", if_instr, img(exp_pc));
        exp_pc = exp_pc + 32'd4;
        pops++;
      end
    end
    redirect = 1'b0;
    chk("rand_progress", (pops >= 300), 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/imem_fetch_queue.md
# imem_fetch_queue

Instruction-fetch front end feeding the pipelined core's IF/ID register from an instruction memory with variable latency. It owns the fetch PC and issues sequential word requests over a req/ack handshake. Returned words are buffered with their PC+4 in a small first-word-fall-through queue, and the queue is flushed when the core redirects on a taken branch or jump. The core's IF stage consumes `if_instr`/`if_pc_incr` and stalls when `if_valid` is low.

## Interface
- `DEPTH`, 4: queue entries; power of two, ≥2.
- `RESET_PC`, 32'h0000_0000: fetch address after reset.

Ports:
- `clk`  in  1  single clock; all state updates on rising edge.
- `rst`  in  1  reset; synchronous, active-high.
- `redirect`  in  1  taken branch/jump this cycle.
- `redirect_pc`  in  32  new fetch address; word aligned.
- `if_ready`  in  1  IF/ID accepts the head entry this cycle.
- `if_valid`  out  1  head entry present.
- `if_instr`  out  32  head instruction word.
- `if_pc_incr`  out  32  head address + 4.
- `mem_req`  out  1  registered; fetch request.
- `mem_addr`  out  32  registered; request word address.
- `mem_ack`  in  1  one-cycle pulse; `mem_rdata` valid.
- `mem_rdata`  in  32  returned instruction word.

## Operation
- Reset values: `mem_req`=0, `mem_addr`=`RESET_PC`, `if_valid`=0, queue count=0, state IDLE, fetch PC=`RESET_PC`. `if_instr`/`if_pc_incr` are don't-care while `if_valid`=0.
- FSM states:
  - IDLE: no request outstanding. When count < `DEPTH`, assert `mem_req` with `mem_addr`=fetch PC next cycle, then go to WAIT.
  - WAIT: request outstanding. `mem_req`/`mem_addr` are held stable until `mem_ack`.
    - On ack, push {`mem_rdata`, `mem_addr`+4} and advance fetch PC by 4.
    - If the projected count after this cycle's push/pop is < `DEPTH`, stay in WAIT and present the next address. This allows back-to-back requests at one word per cycle.
    - Otherwise drop `mem_req` and go to IDLE.
  - DRAIN: a redirect arrived while a request was outstanding. `mem_req` and the stale address are held until `mem_ack`. The returned data is discarded and not pushed. On ack, issue `redirect_pc` (already latched into fetch PC) and go to WAIT.
- Pop: `if_valid && if_ready`. The head advances and the next entry is visible the following cycle.
- Redirect:
  - Count is cleared and fetch PC is loaded with `redirect_pc`.
  - IDLE: request `redirect_pc` next cycle.
  - WAIT with no ack this cycle: go to DRAIN.
  - A pop in the same cycle is ignored because the flush wins.
- Redirect and `mem_ack` in the same cycle: the ack data is discarded, and `redirect_pc` is requested next cycle. No DRAIN.
- Redirect while in DRAIN: overwrite fetch PC and stay in DRAIN.
- Push while full never happens by construction. An ack into a full queue is an assertion failure.
- Address arithmetic is modulo 2^32, so 32'hFFFF_FFFC + 4 wraps to 0.
- `mem_addr[1:0]` is always 0. The low two bits of `redirect_pc` are ignored.

## Timing
- Latency from `mem_ack` to `if_valid` is 1 cycle; the push is registered.
- With zero-wait memory (ack the cycle `mem_req` is seen), throughput is 1 instruction/cycle.
- First request after reset release: `mem_req`=1 in cycle 1 (reset deasserted at cycle 0 edge).
- Redirect to new-address request: 1 cycle from IDLE/WAIT-with-ack; ack cycle + 1 from DRAIN.
- `mem_req` is never deasserted before ack, and `mem_addr` never changes while `mem_req`=1 without ack.
- `rst` mid-request: all state returns to reset values next edge. The memory side must also be reset in the same cycle.

## Structure
- Shared package `fetch_pkg`:
  - state enum {IDLE, WAIT, DRAIN};
  - `INSTR_W`=32;
  - `PC_STEP`=4;
  - default `RESET_PC`.
- Sub-module `fetch_fifo`:
  - parameterised sync FWFT queue, width 64, depth `DEPTH`;
  - ports push/pop/flush/count/head.
- Top: FSM, fetch PC register, space check.

## Test plan
- Reset, then a zero-wait memory returning 0x20080005, 0x20090003 -> `if_valid` from cycle 2; `if_instr`/`if_pc_incr` = 0x20080005/4, then 0x20090003/8. `mem_addr` sequence 0,4,8…
- `if_ready`=0 with zero-wait memory -> exactly 4 pushes. `mem_req` drops after the 4th ack. Raising `if_ready` restarts requests at addr 16.
- Memory with 3-cycle ack latency, redirect to 0x40 one cycle after a request to 8 -> `mem_req` holds addr 8 until ack. Data not enqueued. Next request is 0x40. The first valid `if_pc_incr`=0x44.
- Redirect to 0x100 coincident with an ack for addr 12 and a pop -> queue empty next cycle, ack word dropped, `mem_addr`=0x100 next cycle.
- `redirect_pc`=0xFFFF_FFFC -> entry `if_pc_incr`=0, next `mem_addr`=0.
- `rst` asserted in WAIT with 2 entries queued -> next cycle `if_valid`=0, `mem_req`=0, `mem_addr`=`RESET_PC`.
